// File: rtl/axis_pkg.sv
// Shared stream-fabric definitions: scheduler state encoding and index-width helper.
package axis_pkg;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } wrr_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Registered stream stage with a 2-entry skid buffer: 1-cycle latency, full
// throughput, and an upstream ready that comes straight from a flop.
module axis_skid_reg #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_tmp_data;
  logic             r_tmp_valid;
  logic             r_s_ready;
  logic             w_in;
  logic             w_ready_early;

  assign w_in = s_valid && r_s_ready;
  // Stay ready unless the skid entry is (or is about to become) occupied.
  assign w_ready_early = m_ready || (!r_tmp_valid && (!r_out_valid || !w_in));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_tmp_valid <= 1'b0;
      r_s_ready   <= 1'b0;
    end else begin
      r_s_ready <= w_ready_early;
      if (r_s_ready) begin
        if (m_ready || !r_out_valid) begin
          r_out_valid <= s_valid;
          r_out_data  <= s_data;
        end else begin
          r_tmp_valid <= s_valid;
          r_tmp_data  <= s_data;
        end
      end else if (m_ready) begin
        r_out_valid <= r_tmp_valid;
        r_out_data  <= r_tmp_data;
        r_tmp_valid <= 1'b0;
      end
    end
  end

  assign s_ready = r_s_ready;
  assign m_data  = r_out_data;
  assign m_valid = r_out_valid;

endmodule

// File: rtl/axis_wrr_mux.sv
// N:1 AXI4-Stream packet mux with weighted round-robin: a granted port keeps
// the output for up to weight[i] packets, never interleaving packets.
module axis_wrr_mux
  import axis_pkg::*;
#(
  parameter int S_COUNT      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int USER_WIDTH   = 1,
  parameter int WEIGHT_WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [S_COUNT-1:0]              s_axis_tvalid,
  output logic [S_COUNT-1:0]              s_axis_tready,
  input  logic [S_COUNT-1:0]              s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0]   s_axis_tuser,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [USER_WIDTH-1:0]           m_axis_tuser,
  input  logic [S_COUNT*WEIGHT_WIDTH-1:0] weight,
  output logic                            grant_valid,
  output logic [idx_width(S_COUNT)-1:0]   grant_encoded
);

  localparam int IDX_W  = idx_width(S_COUNT);
  localparam int SKID_W = DATA_WIDTH + USER_WIDTH + 1;

  wrr_state_t              r_state, w_state_next;
  logic [IDX_W-1:0]        r_grant, w_grant_next;
  logic [IDX_W-1:0]        r_ptr, w_ptr_next;
  logic                    r_grant_valid, w_grant_valid_next;
  logic [WEIGHT_WIDTH-1:0] r_credit, w_credit_next, w_credit_dec;

  logic [WEIGHT_WIDTH-1:0] w_weight [S_COUNT];
  logic [DATA_WIDTH-1:0]   w_tdata  [S_COUNT];
  logic [USER_WIDTH-1:0]   w_tuser  [S_COUNT];
  logic [S_COUNT-1:0]      w_eligible;
  logic                    w_found;
  logic [IDX_W-1:0]        w_sel;
  logic                    w_owner_active;
  logic                    w_grant_tvalid;
  logic                    w_in_valid;
  logic                    w_in_last;
  logic                    w_hs;
  logic                    w_skid_ready;
  logic [SKID_W-1:0]       w_in_data;
  logic [SKID_W-1:0]       w_out_data;

  genvar gi;
  generate
    for (gi = 0; gi < S_COUNT; gi++) begin : g_port
      assign w_weight[gi]      = weight[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      assign w_tdata[gi]       = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign w_tuser[gi]       = s_axis_tuser[gi*USER_WIDTH +: USER_WIDTH];
      assign w_eligible[gi]    = s_axis_tvalid[gi] && (w_weight[gi] != '0);
      assign s_axis_tready[gi] = w_owner_active && (r_grant == IDX_W'(gi)) && w_skid_ready;
    end
  endgenerate

  assign w_owner_active = r_grant_valid && (r_state == ACTIVE || r_state == HOLD);
  assign w_grant_tvalid = s_axis_tvalid[r_grant];
  assign w_in_valid     = w_owner_active && w_grant_tvalid;
  assign w_in_last      = s_axis_tlast[r_grant];
  assign w_hs           = w_in_valid && w_skid_ready;
  assign w_in_data      = {w_in_last, w_tuser[r_grant], w_tdata[r_grant]};
  assign w_credit_dec   = (r_credit != '0) ? r_credit - WEIGHT_WIDTH'(1) : '0;

  // Search pointer+1 .. pointer+S_COUNT; iterating downward lets the nearest hit win.
  always_comb begin
    int j;
    j       = 0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = S_COUNT; k >= 1; k--) begin
      j = int'(r_ptr) + k;
      if (j >= S_COUNT) j = j - S_COUNT;
      if (w_eligible[j[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_sel   = j[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_grant_next       = r_grant;
    w_grant_valid_next = r_grant_valid;
    w_ptr_next         = r_ptr;
    w_credit_next      = r_credit;
    case (r_state)
      ARB: begin
        if (w_found) begin
          w_state_next       = ACTIVE;
          w_grant_next       = w_sel;
          w_ptr_next         = w_sel;
          w_grant_valid_next = 1'b1;
          w_credit_next      = w_weight[w_sel];
        end
      end
      ACTIVE, HOLD: begin
        if (r_state == HOLD && !w_grant_tvalid) begin
          w_state_next       = ARB;
          w_grant_valid_next = 1'b0;
          w_credit_next      = '0;
        end else begin
          w_state_next = ACTIVE;
          if (w_hs && w_in_last) begin
            // A port disabled mid-turn gives up the grant at its packet boundary.
            if (w_credit_dec != '0 && w_weight[r_grant] != '0) begin
              w_state_next  = HOLD;
              w_credit_next = w_credit_dec;
            end else begin
              w_state_next       = ARB;
              w_grant_valid_next = 1'b0;
              w_credit_next      = '0;
            end
          end
        end
      end
      default: begin
        w_state_next       = ARB;
        w_grant_valid_next = 1'b0;
        w_credit_next      = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ARB;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_ptr         <= IDX_W'(S_COUNT - 1);
      r_credit      <= '0;
    end else begin
      r_state       <= w_state_next;
      r_grant       <= w_grant_next;
      r_grant_valid <= w_grant_valid_next;
      r_ptr         <= w_ptr_next;
      r_credit      <= w_credit_next;
    end
  end

  axis_skid_reg #(
    .WIDTH(SKID_W)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .s_data (w_in_data),
    .s_valid(w_in_valid),
    .s_ready(w_skid_ready),
    .m_data (w_out_data),
    .m_valid(m_axis_tvalid),
    .m_ready(m_axis_tready)
  );

  assign {m_axis_tlast, m_axis_tuser, m_axis_tdata} = w_out_data;
  assign grant_valid   = r_grant_valid;
  assign grant_encoded = r_grant;

endmodule

// File: tb/tb_axis_wrr_mux.sv
// Directed bench for axis_wrr_mux: per-port packet sources feed a scoreboard
// that is checked against every output beat.
module tb_axis_wrr_mux;

  localparam int S_COUNT      = 4;
  localparam int DATA_WIDTH   = 8;
  localparam int USER_WIDTH   = 1;
  localparam int WEIGHT_WIDTH = 4;
  localparam int IDX_W        = $clog2(S_COUNT);

  logic                            clk = 1'b0;
  logic                            rst;
  logic [S_COUNT*DATA_WIDTH-1:0]   s_axis_tdata;
  logic [S_COUNT-1:0]              s_axis_tvalid;
  logic [S_COUNT-1:0]              s_axis_tready;
  logic [S_COUNT-1:0]              s_axis_tlast;
  logic [S_COUNT*USER_WIDTH-1:0]   s_axis_tuser;
  logic [DATA_WIDTH-1:0]           m_axis_tdata;
  logic                            m_axis_tvalid;
  logic                            m_axis_tready;
  logic                            m_axis_tlast;
  logic [USER_WIDTH-1:0]           m_axis_tuser;
  logic [S_COUNT*WEIGHT_WIDTH-1:0] weight;
  logic                            grant_valid;
  logic [IDX_W-1:0]                grant_encoded;

  always #5 clk = ~clk;

  axis_wrr_mux #(
    .S_COUNT     (S_COUNT),
    .DATA_WIDTH  (DATA_WIDTH),
    .USER_WIDTH  (USER_WIDTH),
    .WEIGHT_WIDTH(WEIGHT_WIDTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tuser (s_axis_tuser),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser),
    .weight       (weight),
    .grant_valid  (grant_valid),
    .grant_encoded(grant_encoded)
  );

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [USER_WIDTH-1:0] user;
    logic                  last;
  } beat_t;

  beat_t sb[$];
  int    out_ports[$];
  int    hs_cycles[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    pkts_left[S_COUNT];
  int    pkt_len[S_COUNT];
  int    beat_idx[S_COUNT];
  int    seq[S_COUNT];
  int    cyc = 0;
  int    out_beats = 0;
  bit    ready_pattern = 0;
  bit    prev_stall = 0;
  logic [DATA_WIDTH+USER_WIDTH:0] prev_word;
  bit    seen_tready1, seen_gv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive();
    logic [DATA_WIDTH-1:0] d;
    for (int p = 0; p < S_COUNT; p++) begin
      d = DATA_WIDTH'((p << 6) | (seq[p] & 63));
      s_axis_tvalid[p] = (pkts_left[p] > 0);
      s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH] = d;
      s_axis_tuser[p*USER_WIDTH +: USER_WIDTH] = USER_WIDTH'(^d);
      s_axis_tlast[p] = (beat_idx[p] == pkt_len[p] - 1);
    end
    m_axis_tready = ready_pattern ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
  endtask

  task automatic step();
    beat_t e;
    logic [DATA_WIDTH-1:0] d;
    @(negedge clk);
    if (!rst) begin
      chk("tready_onehot0", 32'($onehot0(s_axis_tready)), 1);
      if (prev_stall) begin
        chk("stall_valid", m_axis_tvalid, 1);
        chk("stall_stable", {m_axis_tlast, m_axis_tuser, m_axis_tdata}, prev_word);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        chk("sb_has_entry", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("m_data", m_axis_tdata, e.data);
          chk("m_user", m_axis_tuser, e.user);
          chk("m_last", m_axis_tlast, e.last);
          out_beats++;
          if (m_axis_tlast) out_ports.push_back(int'(m_axis_tdata[7:6]));
          $display("t=%0t out beat data=%02h last=%0b", $time, m_axis_tdata, m_axis_tlast);
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_word  = {m_axis_tlast, m_axis_tuser, m_axis_tdata};
      for (int p = 0; p < S_COUNT; p++) begin
        if (s_axis_tvalid[p] && s_axis_tready[p]) begin
          chk("grant_enc", grant_encoded, p);
          d = s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
          sb.push_back({d, s_axis_tuser[p*USER_WIDTH +: USER_WIDTH], s_axis_tlast[p]});
          hs_cycles.push_back(cyc);
          seq[p]++;
          if (s_axis_tlast[p]) begin
            beat_idx[p] = 0;
            pkts_left[p]--;
          end else begin
            beat_idx[p]++;
          end
        end
      end
    end else begin
      prev_stall = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  function automatic bit idle();
    bit r;
    r = (sb.size() == 0) && !m_axis_tvalid;
    for (int p = 0; p < S_COUNT; p++) if (pkts_left[p] != 0) r = 0;
    return r;
  endfunction

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while (!idle() && n < budget) begin
      step();
      n++;
    end
    chk("drain_in_budget", 32'(idle()), 1);
  endtask

  task automatic clear_sources();
    for (int p = 0; p < S_COUNT; p++) begin
      pkts_left[p] = 0;
      pkt_len[p]   = 1;
      beat_idx[p]  = 0;
    end
    sb.delete();
    out_ports.delete();
    hs_cycles.delete();
    out_beats  = 0;
    prev_stall = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ready_pattern = 0;
    clear_sources();
    drive();
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_m_valid", m_axis_tvalid, 0);
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_grant_enc", grant_encoded, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc = 0;
    drive();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int p = 0; p < S_COUNT; p++) seq[p] = 0;
    weight = {4'd1, 4'd1, 4'd1, 4'd1};

    // Test 1: single port, 1-beat packets, one arbitration bubble each
    do_reset();
    pkts_left[2] = 3;
    drive();
    run_until_idle(60);
    chk("t1_pkts", out_ports.size(), 3);
    if (out_ports.size() == 3) begin
      chk("t1_port0", out_ports[0], 2);
      chk("t1_port2", out_ports[2], 2);
    end
    if (hs_cycles.size() == 3) begin
      chk("t1_gap0", hs_cycles[1] - hs_cycles[0], 2);
      chk("t1_gap1", hs_cycles[2] - hs_cycles[1], 2);
    end

    // Test 2: weighted share {3,1,2,1}, all ports busy for two rounds
    weight = {4'd1, 4'd2, 4'd1, 4'd3};
    do_reset();
    pkts_left[0] = 6; pkts_left[1] = 2; pkts_left[2] = 4; pkts_left[3] = 2;
    drive();
    run_until_idle(200);
    chk("t2_pkts", out_ports.size(), 14);
    if (out_ports.size() == 14) begin
      int exp_order[14] = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0, 1, 2, 2, 3};
      for (int i = 0; i < 14; i++) chk("t2_order", out_ports[i], exp_order[i]);
    end

    // Test 3: port 0 goes idle in HOLD and forfeits remaining credit
    weight = {4'd1, 4'd1, 4'd1, 4'd4};
    do_reset();
    pkts_left[0] = 1; pkts_left[1] = 1;
    drive();
    run_until_idle(60);
    chk("t3_pkts", out_ports.size(), 2);
    if (out_ports.size() == 2) begin
      chk("t3_first", out_ports[0], 0);
      chk("t3_second", out_ports[1], 1);
    end
    if (hs_cycles.size() == 2) chk("t3_hold_arb_gap", hs_cycles[1] - hs_cycles[0], 3);

    // Test 4: disabled port never gets the grant
    weight = {4'd1, 4'd1, 4'd0, 4'd1};
    do_reset();
    pkts_left[1] = 1;
    drive();
    seen_tready1 = 0;
    seen_gv = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      seen_tready1 |= s_axis_tready[1];
      seen_gv |= grant_valid;
    end
    chk("t4_tready1_never", 32'(seen_tready1), 0);
    chk("t4_grant_never", 32'(seen_gv), 0);
    pkts_left[1] = 0;

    // Test 5: 8-beat packet from port 3 under 1,0,0,1 backpressure
    weight = {4'd1, 4'd1, 4'd1, 4'd1};
    do_reset();
    ready_pattern = 1;
    pkts_left[3] = 1;
    pkt_len[3] = 8;
    drive();
    run_until_idle(120);
    chk("t5_beats", out_beats, 8);
    chk("t5_pkts", out_ports.size(), 1);
    ready_pattern = 0;

    // Test 6: reset during beat 3 of a 5-beat packet, then port 0 searched first
    do_reset();
    pkts_left[1] = 1;
    pkt_len[1] = 5;
    drive();
    for (int n = 0; n < 30 && beat_idx[1] != 2; n++) step();
    chk("t6_two_beats_in", beat_idx[1], 2);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_m_valid", m_axis_tvalid, 0);
    chk("t6_grant_valid", grant_valid, 0);
    chk("t6_s_tready", s_axis_tready, 0);
    clear_sources();
    @(posedge clk); #1;
    rst = 1'b0;
    cyc = 0;
    pkts_left[0] = 1; pkts_left[1] = 1;
    drive();
    run_until_idle(60);
    chk("t6_pkts", out_ports.size(), 2);
    if (out_ports.size() == 2) begin
      chk("t6_first_port", out_ports[0], 0);
      chk("t6_second_port", out_ports[1], 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
